// File: rtl/addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pipe
// Description : Pipelined two's-complement adder/subtractor on a Kogge-Stone
//               parallel-prefix carry network. Register ranks are spread
//               evenly across the prefix levels, and the last rank drives the
//               outputs. Results leave on a valid/ready stream. One global
//               enable (= in_ready) stalls every stage together.
// Ports       : clk, rst                  clock, synchronous active-high reset
//               in_valid/in_ready         operand stream handshake
//               in_a, in_b, in_sub        operands; in_sub=1 selects a-b
//               out_valid/out_ready       result stream handshake
//               out_sum                   result modulo 2^WIDTH
//               out_cout                  carry out (sub: 1 iff a >= b)
//               out_ovf                   signed overflow
//               out_zero                  out_sum == 0
// Revision    : 1.0  initial release
// ============================================================================
module addsub_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero
);

   // Level 0 forms g/p. Levels 1..c_LEVELS are the prefix levels.
   localparam int c_LEVELS = $clog2(WIDTH);

   // Level 0 and the prefix levels form c_LEVELS+1 combinational steps. The
   // STAGES-1 internal ranks split these steps into near-equal groups. The
   // sum XOR and the output rank come after the last group.
   function automatic logic f_rank_after(input int lvl);
      logic hit;
      hit = 1'b0;
      for (int k = 1; k < STAGES; k++) begin
         if (((k * (c_LEVELS + 1)) / STAGES) - 1 == lvl) hit = 1'b1;
      end
      return hit;
   endfunction

   generate
      if (WIDTH < 8 || WIDTH > 64 || (WIDTH % 4) != 0) begin : g_bad_width
         $error("addsub_pipe: WIDTH must be 8..64 and a multiple of 4");
      end
      if (STAGES < 1 || STAGES > c_LEVELS + 1) begin : g_bad_stages
         $error("addsub_pipe: STAGES must be 1..ceil(log2(WIDTH))+1");
      end
   endgenerate

   logic w_en;

   // Combinational outputs of each level, before the optional rank.
   logic [c_LEVELS:0][WIDTH-1:0] w_g, w_p, w_pb;
   logic [c_LEVELS:0]            w_cin, w_v;
   // The same signals after the optional rank. The next level reads these.
   logic [c_LEVELS:0][WIDTH-1:0] w_gq, w_pq, w_pbq;
   logic [c_LEVELS:0]            w_cinq, w_vq;

   // ---------------------------------------------------------------- level 0
   logic [WIDTH-1:0] w_bx, w_g0, w_p0;

   assign w_bx = in_b ^ {WIDTH{in_sub}};
   assign w_g0 = in_a & w_bx;
   assign w_p0 = in_a ^ w_bx;

   // Fold the carry-in (the +1 of subtraction) into bit 0's generate. The
   // bit-0 group then no longer depends on anything below it. P[0] is forced
   // to 0, so higher groups that reach bit 0 stop propagating.
   assign w_g[0]   = {w_g0[WIDTH-1:1], w_g0[0] | (w_p0[0] & in_sub)};
   assign w_p[0]   = {w_p0[WIDTH-1:1], 1'b0};
   assign w_pb[0]  = w_p0;
   assign w_cin[0] = in_sub;
   assign w_v[0]   = in_valid;

   // ------------------------------------------------------- prefix levels
   generate
      for (genvar l = 1; l <= c_LEVELS; l++) begin : g_level
         localparam int c_DIST = 1 << (l - 1);
         for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= c_DIST) begin : g_merge
               assign w_g[l][i] = w_gq[l-1][i] | (w_pq[l-1][i] & w_gq[l-1][i-c_DIST]);
               assign w_p[l][i] = w_pq[l-1][i] & w_pq[l-1][i-c_DIST];
            end else begin : g_pass
               assign w_g[l][i] = w_gq[l-1][i];
               assign w_p[l][i] = w_pq[l-1][i];
            end
         end
         assign w_pb[l]  = w_pbq[l-1];
         assign w_cin[l] = w_cinq[l-1];
         assign w_v[l]   = w_vq[l-1];
      end
   endgenerate

   // -------------------------------------------------------- internal ranks
   generate
      for (genvar l = 0; l <= c_LEVELS; l++) begin : g_rank
         if (f_rank_after(l)) begin : g_reg
            logic [WIDTH-1:0] r_g, r_p, r_pb;
            logic             r_cin, r_v;

            always_ff @(posedge clk) begin
               if (rst) begin
                  r_v   <= 1'b0;
                  r_g   <= '0;
                  r_p   <= '0;
                  r_pb  <= '0;
                  r_cin <= 1'b0;
               end else if (w_en) begin
                  r_v <= w_v[l];
                  // Data is only captured for real beats. A bubble leaves
                  // the previous contents in place.
                  if (w_v[l]) begin
                     r_g   <= w_g[l];
                     r_p   <= w_p[l];
                     r_pb  <= w_pb[l];
                     r_cin <= w_cin[l];
                  end
               end
            end

            assign w_gq[l]   = r_g;
            assign w_pq[l]   = r_p;
            assign w_pbq[l]  = r_pb;
            assign w_cinq[l] = r_cin;
            assign w_vq[l]   = r_v;
         end else begin : g_wire
            assign w_gq[l]   = w_g[l];
            assign w_pq[l]   = w_p[l];
            assign w_pbq[l]  = w_pb[l];
            assign w_cinq[l] = w_cin[l];
            assign w_vq[l]   = w_v[l];
         end
      end
   endgenerate

   // ----------------------------------------------------- sum and output rank
   // After the last level, G[i] is the carry into bit i+1.
   logic [WIDTH:0]   w_c;
   logic [WIDTH-1:0] w_sum;
   logic             w_cout, w_ovf, w_zero;
   logic             w_unused;

   assign w_c    = {w_gq[c_LEVELS], w_cinq[c_LEVELS]};
   assign w_sum  = w_pbq[c_LEVELS] ^ w_c[WIDTH-1:0];
   assign w_cout = w_c[WIDTH];
   assign w_ovf  = w_c[WIDTH] ^ w_c[WIDTH-1];
   assign w_zero = (w_sum == '0);

   // The group propagate is not needed after the final level.
   assign w_unused = ^w_pq[c_LEVELS];

   logic [WIDTH-1:0] r_sum;
   logic             r_cout, r_ovf, r_zero, r_out_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_zero      <= 1'b1;   // consistent with the cleared sum
      end else if (w_en) begin
         r_out_valid <= w_vq[c_LEVELS];
         if (w_vq[c_LEVELS]) begin
            r_sum  <= w_sum;
            r_cout <= w_cout;
            r_ovf  <= w_ovf;
            r_zero <= w_zero;
         end
      end
   end

   // The whole pipe advances together, so a stall is a single enable.
   assign in_ready  = !r_out_valid || out_ready;
   assign w_en      = in_ready;

   assign out_valid = r_out_valid;
   assign out_sum   = r_sum;
   assign out_cout  = r_cout;
   assign out_ovf   = r_ovf;
   assign out_zero  = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_pipe
// Description : Self-checking bench for addsub_pipe. The main instance is
//               32 bits with 2 stages. Six more instances cover
//               WIDTH {8,16,64} x STAGES {1,3}. All instances are checked
//               against an arithmetic reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_addsub_pipe;

   localparam int W   = 32;
   localparam int S   = 2;
   localparam int NSW = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         in_valid, in_sub, out_ready;
   logic [W-1:0] in_a, in_b;
   logic         in_ready, out_valid, out_cout, out_ovf, out_zero;
   logic [W-1:0] out_sum;

   int n_cmp = 0;
   int n_bad = 0;

   addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
   );

   // ------------------------------------------------------- sweep instances
   function automatic int sw_w(input int k);
      return (k < 2) ? 8 : (k < 4) ? 16 : 64;
   endfunction
   function automatic int sw_s(input int k);
      return (k % 2 == 0) ? 1 : 3;
   endfunction

   logic        sw_valid, sw_sub;
   logic [63:0] sw_a, sw_b;
   logic [63:0] sw_sum  [NSW];
   logic        sw_ov   [NSW];
   logic        sw_cout [NSW];
   logic        sw_ovf  [NSW];
   logic        sw_zero [NSW];
   logic        sw_ir   [NSW];

   generate
      for (genvar k = 0; k < NSW; k++) begin : g_sw
         localparam int KW = sw_w(k);
         localparam int KS = sw_s(k);
         logic [KW-1:0] s;
         addsub_pipe #(.WIDTH(KW), .STAGES(KS)) u_sw (
            .clk(clk), .rst(rst),
            .in_valid(sw_valid), .in_ready(sw_ir[k]),
            .in_a(sw_a[KW-1:0]), .in_b(sw_b[KW-1:0]), .in_sub(sw_sub),
            .out_valid(sw_ov[k]), .out_ready(1'b1),
            .out_sum(s), .out_cout(sw_cout[k]), .out_ovf(sw_ovf[k]), .out_zero(sw_zero[k])
         );
         assign sw_sum[k] = 64'(s);
      end
   endgenerate

   // -------------------------------------------------------- reference model
   typedef struct packed {
      logic        zero;
      logic        ovf;
      logic        cout;
      logic [63:0] sum;
   } res_t;

   // The model works from the arithmetic meaning of the operands: unsigned
   // sum or difference, unsigned compare, and an exact signed result checked
   // against the representable range.
   function automatic res_t model(input logic [63:0] a_i, input logic [63:0] b_i,
                                  input logic sub, input int w);
      res_t               r;
      logic [63:0]        mask, a, b;
      logic [64:0]        t;
      logic signed [71:0] sa, sb, sr, lim;
      mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      a = a_i & mask;
      b = b_i & mask;
      if (!sub) begin
         t      = {1'b0, a} + {1'b0, b};
         r.cout = t[w];
         r.sum  = t[63:0] & mask;
      end else begin
         r.sum  = (a - b) & mask;
         r.cout = (a >= b);
      end
      sa = $signed({8'd0, a});
      sb = $signed({8'd0, b});
      if (a[w-1]) sa = sa - (72'sd1 <<< w);
      if (b[w-1]) sb = sb - (72'sd1 <<< w);
      sr     = sub ? (sa - sb) : (sa + sb);
      lim    = 72'sd1 <<< (w - 1);
      r.ovf  = (sr >= lim) || (sr < -lim);
      r.zero = (r.sum == 64'd0);
      return r;
   endfunction

   function automatic res_t main_out();
      res_t r;
      r.zero = out_zero;
      r.ovf  = out_ovf;
      r.cout = out_cout;
      r.sum  = 64'(out_sum);
      return r;
   endfunction

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_a = '1; in_b = 32'd1; in_sub = 1'b0; out_ready = 1'b1;
      sw_valid = 1'b1; sw_a = '1; sw_b = 64'd1; sw_sub = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; in_valid = 1'b0; sw_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({out_valid, out_sum, out_cout, out_ovf, out_zero, in_ready} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
         n_bad++;
         $display("FAIL reset_state: got v=%b sum=%h c=%b o=%b z=%b rdy=%b, want v=0 sum=0 c=0 o=0 z=1 rdy=1",
                  out_valid, out_sum, out_cout, out_ovf, out_zero, in_ready);
      end
      // A beat presented during reset is dropped, so nothing appears later.
      for (int i = 0; i < S + 2; i++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_drop: out_valid got %b want 0 (cycle %0d)", out_valid, i);
         end
      end
   endtask

   task automatic test_directed(input string name, input logic [31:0] a, input logic [31:0] b,
                                input logic sub, input logic [31:0] esum,
                                input logic ecout, input logic eovf, input logic ezero);
      @(posedge clk);
      #1;
      out_ready = 1'b1; in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub;
      @(posedge clk);                       // beat accepted at this edge
      #1;
      in_valid = 1'b0;
      for (int k = 1; k < S; k++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_latency_early: out_valid got %b want 0 at cycle %0d", name, out_valid, k);
         end
      end
      @(negedge clk);
      n_cmp++;
      if ({out_valid, out_sum, out_cout, out_ovf, out_zero} !== {1'b1, esum, ecout, eovf, ezero}) begin
         n_bad++;
         $display("FAIL %s: got v=%b sum=%h c=%b o=%b z=%b, want v=1 sum=%h c=%b o=%b z=%b",
                  name, out_valid, out_sum, out_cout, out_ovf, out_zero, esum, ecout, eovf, ezero);
      end
   endtask

   task automatic test_back_to_back();
      res_t        q[$];
      res_t        exp, cur, held;
      logic        holding;
      int          sent, got, cyc;
      logic [31:0] a, b;
      holding = 1'b0; sent = 0; got = 0; cyc = 0;
      @(posedge clk);
      #1;
      while ((sent < 100 || q.size() != 0) && cyc < 3000) begin
         if (sent < 100 && ($urandom % 4) != 0) begin
            a = $urandom;
            case ($urandom % 6)
               0:       b = a;
               1:       begin a = 32'h8000_0000; b = $urandom % 3; end
               2:       begin a = 32'hFFFF_FFFF; b = $urandom % 3; end
               default: b = $urandom;
            endcase
            in_valid = 1'b1; in_a = a; in_b = b; in_sub = $urandom % 2;
         end else begin
            in_valid = 1'b0;
         end
         out_ready = ($urandom % 3) != 0;
         @(negedge clk);
         cur = main_out();
         n_cmp++;
         if (in_ready !== (!out_valid || out_ready)) begin
            n_bad++;
            $display("FAIL b2b_in_ready: got %b want %b (cycle %0d)", in_ready, !out_valid || out_ready, cyc);
         end
         if (holding) begin
            n_cmp++;
            if (out_valid !== 1'b1 || cur !== held) begin
               n_bad++;
               $display("FAIL b2b_stall_hold: got v=%b %h want v=1 %h (cycle %0d)", out_valid, cur, held, cyc);
            end
         end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_bad++;
               $display("FAIL b2b_spurious: got beat %h want none (cycle %0d)", cur, cyc);
            end else begin
               exp = q.pop_front();
               got++;
               if (cur !== exp) begin
                  n_bad++;
                  $display("FAIL b2b_data[%0d]: got %h want %h", got - 1, cur, exp);
               end
            end
         end
         holding = out_valid && !out_ready;
         held    = cur;
         if (in_valid && in_ready) begin
            q.push_back(model(64'(in_a), 64'(in_b), in_sub, W));
            sent++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_cmp++;
      if (sent != 100 || got != 100 || q.size() != 0) begin
         n_bad++;
         $display("FAIL b2b_count: got sent=%0d received=%0d pending=%0d want 100/100/0", sent, got, q.size());
      end
   endtask

   task automatic test_reset_inflight();
      @(posedge clk);
      #1;
      out_ready = 1'b1; in_valid = 1'b1; in_a = 32'h1111_1111; in_b = 32'h2; in_sub = 1'b0;
      @(posedge clk);
      #1;
      in_a = 32'h3333_3333;
      @(posedge clk);
      #1;
      // Both beats are inside the pipe. Raise reset before either one handshakes.
      in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({out_valid, in_ready, out_sum} !== {1'b0, 1'b1, 32'd0}) begin
         n_bad++;
         $display("FAIL midreset_state: got v=%b rdy=%b sum=%h want v=0 rdy=1 sum=0", out_valid, in_ready, out_sum);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 2 * S + 4; i++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_stale: out_valid got %b want 0 (cycle %0d)", out_valid, i);
         end
      end
   endtask

   task automatic test_sweep();
      logic [63:0] ha [8];
      logic [63:0] hb [8];
      logic        hs [8];
      logic        hv [8];
      res_t        exp, cur;
      int          idx;
      logic        ev;
      for (int i = 0; i < 8; i++) begin
         hv[i] = 1'b0; ha[i] = '0; hb[i] = '0; hs[i] = 1'b0;
      end
      @(negedge clk);
      for (int j = 0; j < 65536 + 1500 + 8; j++) begin
         if (j < 65536) begin
            sw_valid = 1'b1; sw_a = 64'(j[15:8]); sw_b = 64'(j[7:0]); sw_sub = $urandom % 2;
         end else if (j < 65536 + 1500) begin
            sw_valid = ($urandom % 4) != 0; sw_a = {$urandom, $urandom}; sw_b = {$urandom, $urandom};
            sw_sub = $urandom % 2;
         end else begin
            sw_valid = 1'b0;
         end
         hv[j % 8] = sw_valid; ha[j % 8] = sw_a; hb[j % 8] = sw_b; hs[j % 8] = sw_sub;
         @(posedge clk);
         @(negedge clk);
         for (int k = 0; k < NSW; k++) begin
            idx = j - sw_s(k) + 1;
            ev  = (idx >= 0) && hv[idx % 8];
            n_cmp++;
            if (sw_ov[k] !== ev || sw_ir[k] !== 1'b1) begin
               n_bad++;
               $display("FAIL sweep_valid W%0d/S%0d j=%0d: got v=%b rdy=%b want v=%b rdy=1",
                        sw_w(k), sw_s(k), j, sw_ov[k], sw_ir[k], ev);
            end
            if (ev) begin
               exp = model(ha[idx % 8], hb[idx % 8], hs[idx % 8], sw_w(k));
               cur.zero = sw_zero[k]; cur.ovf = sw_ovf[k]; cur.cout = sw_cout[k]; cur.sum = sw_sum[k];
               n_cmp++;
               if (cur !== exp) begin
                  n_bad++;
                  $display("FAIL sweep_data W%0d/S%0d j=%0d a=%h b=%h sub=%b: got %h want %h",
                           sw_w(k), sw_s(k), j, ha[idx % 8], hb[idx % 8], hs[idx % 8], cur, exp);
               end
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
      sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_sub = 1'b0;

      test_reset();
      test_directed("sub_10_3",     32'h0000_000A, 32'h0000_0003, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0);
      test_directed("sub_0_1",      32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      test_directed("sub_min_1",    32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
      test_directed("add_ones_1",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      test_directed("add_max_1",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      test_directed("sub_x_x",      32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      test_directed("add_small",    32'h0000_0005, 32'h0000_0009, 1'b0, 32'h0000_000E, 1'b0, 1'b0, 1'b0);
      test_back_to_back();
      test_reset_inflight();
      test_sweep();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
